// File: rtl/ita_periph_resp_pkg.sv
// Shared types, constants and the register-window decoder for the ITA timer peripheral.
`include "mcu_defines.v"
`include "ita_defines.v"

package ita_periph_resp_pkg;

    localparam int XLEN = `XLEN;
    localparam int AW   = `PC_SIZE;

    localparam logic [1:0] ST_IDLE = `ITA_ST_IDLE;
    localparam logic [1:0] ST_WAIT = `ITA_ST_WAIT;
    localparam logic [1:0] ST_RESP = `ITA_ST_RESP;

    localparam int CTRL_EN     = `ITA_CTRL_EN;
    localparam int CTRL_IRQ_EN = `ITA_CTRL_IRQ_EN;
    localparam int CTRL_RELOAD = `ITA_CTRL_RELOAD;

    localparam logic [AW-1:0] OFF_CTRL    = AW'(`ITA_OFF_CTRL);
    localparam logic [AW-1:0] OFF_STATUS  = AW'(`ITA_OFF_STATUS);
    localparam logic [AW-1:0] OFF_COUNT   = AW'(`ITA_OFF_COUNT);
    localparam logic [AW-1:0] OFF_COMPARE = AW'(`ITA_OFF_COMPARE);
    localparam logic [AW-1:0] OFF_SCRATCH = AW'(`ITA_OFF_SCRATCH);

    localparam logic [XLEN-1:0] COMPARE_RST = XLEN'(`ITA_COMPARE_RST);

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_COUNT,
        SEL_COMPARE,
        SEL_SCRATCH,
        SEL_NONE
    } reg_sel_e;

    typedef struct packed {
        logic            wr;
        logic            rd;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
    } ita_req_t;

    // Byte lanes within a word are ignored; anything past SCRATCH is unmapped.
    function automatic reg_sel_e decode_offset(input logic [AW-1:0] offset);
        logic [AW-3:0] word;
        reg_sel_e      sel;
        word = offset[AW-1:2];
        sel  = SEL_NONE;
        if (word == OFF_CTRL[AW-1:2])         sel = SEL_CTRL;
        else if (word == OFF_STATUS[AW-1:2])  sel = SEL_STATUS;
        else if (word == OFF_COUNT[AW-1:2])   sel = SEL_COUNT;
        else if (word == OFF_COMPARE[AW-1:2]) sel = SEL_COMPARE;
        else if (word == OFF_SCRATCH[AW-1:2]) sel = SEL_SCRATCH;
        return sel;
    endfunction

endpackage

// File: rtl/ita_defines.v
// ITA timer peripheral constants: register offsets, CTRL bits, FSM encodings, reset values.
`ifndef ITA_DEFINES_V
`define ITA_DEFINES_V

`define ITA_OFF_CTRL        8'h00
`define ITA_OFF_STATUS      8'h04
`define ITA_OFF_COUNT       8'h08
`define ITA_OFF_COMPARE     8'h0C
`define ITA_OFF_SCRATCH     8'h10

`define ITA_CTRL_EN         0
`define ITA_CTRL_IRQ_EN     1
`define ITA_CTRL_RELOAD     2

`define ITA_ST_IDLE         2'b00
`define ITA_ST_WAIT         2'b01
`define ITA_ST_RESP         2'b10

`define ITA_COMPARE_RST     32'hFFFF_FFFF

`endif

// File: rtl/ita_timer_core.sv
// Free-running COUNT with COMPARE match detection and optional auto-reload.
`include "mcu_defines.v"
`include "ita_defines.v"

module ita_timer_core
    import ita_periph_resp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            reload_i,
    input  logic            cnt_we_i,
    input  logic            cmp_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] count_o,
    output logic [XLEN-1:0] compare_o,
    output logic            match_o
);

    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] count_d;
    logic [XLEN-1:0] compare_q;
    logic [XLEN-1:0] compare_d;
    logic            match;

    assign match = en_i && (count_q == compare_q);

    // A bus write to COUNT takes priority over both increment and reload.
    always_comb begin
        count_d = count_q;
        if (cnt_we_i) begin
            count_d = wdata_i;
        end else if (en_i) begin
            if (match && reload_i) begin
                count_d = '0;
            end else begin
                count_d = count_q + XLEN'(1);
            end
        end
    end

    always_comb begin
        compare_d = compare_q;
        if (cmp_we_i) begin
            compare_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= COMPARE_RST;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign match_o   = match;

endmodule

// File: rtl/mcu_defines.v
// MCU-wide bus widths shared by every peripheral on the ITA fabric.
`ifndef MCU_DEFINES_V
`define MCU_DEFINES_V

`define XLEN    32
`define PC_SIZE 32

`endif

// File: rtl/ita_periph_resp.sv
// ITA slave front-end for the timer peripheral: request FSM, register decode, CTRL/STATUS/SCRATCH.
// Define ITA_RESP_WAIT_EN to insert one WAIT state before the response (latency 2 instead of 1).
`include "mcu_defines.v"
`include "ita_defines.v"

module ita_periph_resp
    import ita_periph_resp_pkg::*;
#(
    parameter logic [`PC_SIZE-1:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ita_i_valid,
    input  logic                ita_i_wr,
    input  logic                ita_i_rd,
    input  logic [`PC_SIZE-1:0] ita_i_addr,
    input  logic [`XLEN-1:0]    ita_i_wdata,
    output logic [`XLEN-1:0]    ita_o_rdata,
    output logic                ita_o_ready,
    output logic                irq_o
);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    ita_req_t        req_q;
    ita_req_t        req_d;

    logic [2:0]      ctrl_q;
    logic [2:0]      ctrl_d;
    logic            status_q;
    logic            status_d;
    logic [XLEN-1:0] scratch_q;
    logic [XLEN-1:0] scratch_d;

    logic [AW-1:0]   offset;
    reg_sel_e        sel;
    logic            in_resp;
    logic            do_wr;
    logic            do_rd;
    logic            we_ctrl;
    logic            we_status;
    logic            we_count;
    logic            we_compare;
    logic            we_scratch;

    logic [XLEN-1:0] count;
    logic [XLEN-1:0] compare;
    logic            match;
    logic [XLEN-1:0] rdata;

    // Request FSM; a valid seen in RESP is dropped because only IDLE samples.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (ita_i_valid) begin
                    req_d.wr    = ita_i_wr;
                    req_d.rd    = ita_i_rd;
                    req_d.addr  = ita_i_addr;
                    req_d.wdata = ita_i_wdata;
`ifdef ITA_RESP_WAIT_EN
                    state_d     = ST_WAIT;
`else
                    state_d     = ST_RESP;
`endif
                end
            end
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Addresses below BASE_ADDR wrap to huge offsets and decode as unmapped.
    assign offset  = req_q.addr - BASE_ADDR;
    assign sel     = decode_offset(offset);
    assign in_resp = (state_q == ST_RESP);
    assign do_wr   = in_resp && req_q.wr;
    assign do_rd   = in_resp && req_q.rd && !req_q.wr;

    assign we_ctrl    = do_wr && (sel == SEL_CTRL);
    assign we_status  = do_wr && (sel == SEL_STATUS);
    assign we_count   = do_wr && (sel == SEL_COUNT);
    assign we_compare = do_wr && (sel == SEL_COMPARE);
    assign we_scratch = do_wr && (sel == SEL_SCRATCH);

    ita_timer_core u_timer_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (ctrl_q[CTRL_EN]),
        .reload_i  (ctrl_q[CTRL_RELOAD]),
        .cnt_we_i  (we_count),
        .cmp_we_i  (we_compare),
        .wdata_i   (req_q.wdata),
        .count_o   (count),
        .compare_o (compare),
        .match_o   (match)
    );

    always_comb begin
        ctrl_d    = we_ctrl ? req_q.wdata[2:0] : ctrl_q;
        scratch_d = we_scratch ? req_q.wdata : scratch_q;
        // A hardware match in the same cycle beats a W1C clear.
        if (match) begin
            status_d = 1'b1;
        end else if (we_status && req_q.wdata[0]) begin
            status_d = 1'b0;
        end else begin
            status_d = status_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            status_q  <= 1'b0;
            scratch_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            scratch_q <= scratch_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (do_rd) begin
            case (sel)
                SEL_CTRL:    rdata = {{(XLEN-3){1'b0}}, ctrl_q};
                SEL_STATUS:  rdata = {{(XLEN-1){1'b0}}, status_q};
                SEL_COUNT:   rdata = count;
                SEL_COMPARE: rdata = compare;
                SEL_SCRATCH: rdata = scratch_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign ita_o_rdata = rdata;
    assign ita_o_ready = in_resp;
    assign irq_o       = status_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_ita_periph_resp.sv
// Self-checking bench for ita_periph_resp: constant vector table, directed timer/reset sequences,
// and randomized bus traffic checked against a word-array register model.
module tb_ita_periph_resp;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef ITA_RESP_WAIT_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ita_periph_resp #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ita_i_valid (valid),
        .ita_i_wr    (wr),
        .ita_i_rd    (rd),
        .ita_i_addr  (addr),
        .ita_i_wdata (wdata),
        .ita_o_rdata (rdata),
        .ita_o_ready (ready),
        .irq_o       (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: word 0 CTRL, 1 STATUS, 2 COUNT, 3 COMPARE, 4 SCRATCH.
    logic [31:0] m_reg [5];
    logic [31:0] m_nxt [5];
    logic        m_hit;
    int          m_idx;
    logic        p_wr = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;
    logic        chk_irq = 1'b0;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o < 32'd20) return int'(o >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] m_expect(input logic w, input logic r, input logic [31:0] a);
        int i;
        i = widx(a);
        if (w || !r || i < 0) return 32'h0;
        return m_reg[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg[0] <= 32'h0;
            m_reg[1] <= 32'h0;
            m_reg[2] <= 32'h0;
            m_reg[3] <= 32'hFFFF_FFFF;
            m_reg[4] <= 32'h0;
        end else begin
            for (int k = 0; k < 5; k++) m_nxt[k] = m_reg[k];
            m_hit = m_reg[0][0] && (m_reg[2] == m_reg[3]);
            if (m_reg[0][0]) m_nxt[2] = (m_hit && m_reg[0][2]) ? 32'h0 : m_reg[2] + 32'h1;
            if (m_hit) m_nxt[1] = 32'h1;
            if (p_wr) begin
                m_idx = widx(p_addr);
                case (m_idx)
                    0:       m_nxt[0] = p_wdata & 32'h7;
                    1:       if (p_wdata[0] && !m_hit) m_nxt[1] = 32'h0;
                    2, 3, 4: m_nxt[m_idx] = p_wdata;
                    default: ;
                endcase
            end
            for (int k = 0; k < 5; k++) m_reg[k] <= m_nxt[k];
        end
    end

    always @(negedge clk) begin
        if (chk_irq) check("irq_level", {31'h0, irq}, {31'h0, m_reg[1][0] & m_reg[0][1]});
    end

    task automatic xfer(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
        int  cyc;
        bit  seen;
        @(posedge clk);
        #1;
        valid = 1'b1; wr = w; rd = r; addr = a; wdata = d;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (ready) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready, expected ready within 10 cycles (addr 0x%08h)", a);
            valid = 1'b0; wr = 1'b0; rd = 1'b0;
            got = '0;
            return;
        end
        check("latency", 32'(cyc - 1), 32'(EXP_LAT));
        got = rdata;
        check("rdata_model", rdata, m_expect(w, r, a));
        $display("xfer wr=%0d rd=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h lat=%0d", w, r, a, d, rdata, cyc - 1);
        p_wr = w; p_addr = a; p_wdata = d;
        @(posedge clk);
        #1;
        p_wr = 1'b0;
        valid = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("ready_strobe", {31'h0, ready}, 32'h0);
        check("rdata_idle", rdata, 32'h0);
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] off;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t        tbl [19];
    logic [31:0] got;
    bit          seen_irq;

    initial begin
        tbl[0]  = '{0, 1, 32'h00, 32'h0,          32'h0,          "rst_ctrl"};
        tbl[1]  = '{0, 1, 32'h04, 32'h0,          32'h0,          "rst_status"};
        tbl[2]  = '{0, 1, 32'h08, 32'h0,          32'h0,          "rst_count"};
        tbl[3]  = '{0, 1, 32'h0C, 32'h0,          32'hFFFF_FFFF,  "rst_compare"};
        tbl[4]  = '{0, 1, 32'h10, 32'h0,          32'h0,          "rst_scratch"};
        tbl[5]  = '{1, 0, 32'h10, 32'hDEAD_BEEF,  32'h0,          "wr_scratch"};
        tbl[6]  = '{0, 1, 32'h10, 32'h0,          32'hDEAD_BEEF,  "rd_scratch"};
        tbl[7]  = '{0, 1, 32'h20, 32'h0,          32'h0,          "rd_unmapped"};
        tbl[8]  = '{1, 0, 32'h20, 32'h1234_5678,  32'h0,          "wr_unmapped"};
        tbl[9]  = '{0, 1, 32'h10, 32'h0,          32'hDEAD_BEEF,  "scratch_kept"};
        tbl[10] = '{0, 1, 32'h0C, 32'h0,          32'hFFFF_FFFF,  "compare_kept"};
        tbl[11] = '{0, 1, 32'h00, 32'h0,          32'h0,          "ctrl_kept"};
        tbl[12] = '{1, 1, 32'h10, 32'hCAFE_F00D,  32'h0,          "wr_and_rd"};
        tbl[13] = '{0, 1, 32'h13, 32'h0,          32'hCAFE_F00D,  "rd_lowbits"};
        tbl[14] = '{0, 0, 32'h10, 32'h0,          32'h0,          "noop"};
        tbl[15] = '{0, 1, 32'h14, 32'h0,          32'h0,          "rd_past_end"};
        tbl[16] = '{0, 1, 32'hFFFF_FFFC, 32'h0,   32'h0,          "rd_below_base"};
        tbl[17] = '{1, 0, 32'h0C, 32'h5,          32'h0,          "wr_compare"};
        tbl[18] = '{0, 1, 32'h0C, 32'h0,          32'h5,          "rd_compare"};

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk_irq = 1'b1;

        for (int i = 0; i < 19; i++) begin
            xfer(tbl[i].w, tbl[i].r, BASE + tbl[i].off, tbl[i].d, got);
            check(tbl[i].nm, got, tbl[i].exp);
        end

        // Match with interrupt enabled, then W1C.
        xfer(1, 0, BASE + 32'h00, 32'h3, got);
        seen_irq = 0;
        for (int c = 0; c < 30 && !seen_irq; c++) begin
            @(negedge clk);
            if (irq) seen_irq = 1;
        end
        check("irq_on_match", {31'h0, seen_irq}, 32'h1);
        xfer(0, 1, BASE + 32'h04, 32'h0, got);
        check("status_match", got, 32'h1);
        xfer(1, 0, BASE + 32'h04, 32'h1, got);
        check("irq_w1c", {31'h0, irq}, 32'h0);

        // Auto-reload at COMPARE=3.
        xfer(1, 0, BASE + 32'h00, 32'h0, got);
        xfer(1, 0, BASE + 32'h08, 32'h0, got);
        xfer(1, 0, BASE + 32'h0C, 32'h3, got);
        xfer(1, 0, BASE + 32'h00, 32'h5, got);
        for (int k = 0; k < 6; k++) begin
            xfer(0, 1, BASE + 32'h08, 32'h0, got);
            check("reload_bound", {31'h0, got <= 32'h3}, 32'h1);
        end
        xfer(0, 1, BASE + 32'h04, 32'h0, got);
        check("reload_status", got, 32'h1);

        // Wrap-around and write-over-increment.
        xfer(1, 0, BASE + 32'h00, 32'h0, got);
        xfer(1, 0, BASE + 32'h08, 32'hFFFF_FFFE, got);
        xfer(1, 0, BASE + 32'h00, 32'h1, got);
        xfer(0, 1, BASE + 32'h08, 32'h0, got);
        check("count_wrap", got, 32'(EXP_LAT - 1));
        xfer(1, 0, BASE + 32'h08, 32'h100, got);
        xfer(0, 1, BASE + 32'h08, 32'h0, got);
        check("count_wr_wins", got, 32'h100 + 32'h1 + 32'(EXP_LAT));

        // Reset in the middle of a SCRATCH write.
        xfer(1, 0, BASE + 32'h10, 32'h5555_AAAA, got);
        @(posedge clk);
        #1;
        valid = 1'b1; wr = 1'b1; rd = 1'b0; addr = BASE + 32'h10; wdata = 32'h7777_7777;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        valid = 1'b0; wr = 1'b0;
        #1;
        check("midrst_ready", {31'h0, ready}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        #1;
        rst_n = 1'b1;
        xfer(0, 1, BASE + 32'h10, 32'h0, got);
        check("midrst_scratch", got, 32'h0);
        xfer(0, 1, BASE + 32'h0C, 32'h0, got);
        check("midrst_compare", got, 32'hFFFF_FFFF);
        xfer(0, 1, BASE + 32'h00, 32'h0, got);
        check("midrst_ctrl", got, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int unsigned pick;
            logic [31:0] off;
            logic [31:0] d;
            logic        w;
            logic        r;
            pick = $urandom_range(0, 9);
            if (pick < 8) off = 32'($urandom_range(0, 4)) * 32'd4 + 32'($urandom_range(0, 3));
            else          off = 32'h14 + 32'($urandom_range(0, 11)) * 32'd4;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            if ((off[4:2] == 3'd2 || off[4:2] == 3'd3) && $urandom_range(0, 1) == 1)
                d = 32'($urandom_range(0, 15));
            xfer(w, r, BASE + off, d, got);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ita_periph_resp.md
ITA_PERIPH_RESP -- requirements
Module: ita_periph_resp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000: ITA base address of the 5-word register window.
REQ-002 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ita_i_valid  input  1  initiator request valid, held until ita_o_ready.
REQ-005 SHALL have port ita_i_wr  input  1  write request.
REQ-006 SHALL have port ita_i_rd  input  1  read request.
REQ-007 SHALL have port ita_i_addr  input  `PC_SIZE  byte address.
REQ-008 SHALL have port ita_i_wdata  input  `XLEN  write data.
REQ-009 SHALL have port ita_o_rdata  output  `XLEN  read data, valid while ita_o_ready=1.
REQ-010 SHALL have port ita_o_ready  output  1  one-cycle response strobe.
REQ-011 SHALL have port irq_o  output  1  level interrupt = STATUS.match & CTRL.irq_en.

Function
REQ-012 SHALL decode offsets from BASE_ADDR as follows, ignoring addr[1:0]:
- 0x00 CTRL: [0] en, [1] irq_en, [2] auto_reload.
- 0x04 STATUS: [0] match, write-1-to-clear.
- 0x08 COUNT.
- 0x0C COMPARE.
- 0x10 SCRATCH.
REQ-013 SHALL run an FSM with states IDLE, WAIT, RESP; IDLE->RESP when ita_i_valid=1 (or IDLE->WAIT->RESP under REQ-024); RESP->IDLE unconditionally.
REQ-014 SHALL latch wr, rd, addr and wdata on the IDLE cycle in which ita_i_valid=1.
REQ-015 SHALL assert ita_o_ready only in RESP, for exactly one cycle, giving a latency of 1 cycle from the valid sample.
REQ-016 SHALL commit a write in the RESP cycle; register contents are visible from the following cycle.
REQ-017 SHALL drive the read value on ita_o_rdata in RESP, sampled at RESP, and drive 0 in all other states.
REQ-018 SHALL treat valid with wr=1 and rd=1 as a write; SHALL treat valid with neither as a no-op that still returns ready with rdata=0.
REQ-019 SHALL, for an unmapped address in or outside the window, return rdata=0, ignore writes and still assert ready.
REQ-020 SHALL increment COUNT by 1 each cycle while CTRL.en=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-021 SHALL set STATUS.match on the cycle COUNT==COMPARE while en=1, and when auto_reload=1 SHALL load COUNT=0 on the next cycle instead of incrementing.
REQ-022 SHALL resolve simultaneous events as follows:
- A bus write to COUNT overrides increment and reload.
- A hardware match set overrides a same-cycle W1C clear.
REQ-023 SHALL only accept a new request after returning to IDLE; a valid still high in the RESP cycle is not re-sampled.

Configuration
REQ-024 SHALL insert one WAIT state (IDLE->WAIT->RESP, latency 2) when ITA_RESP_WAIT_EN is defined, and use latency 1 with WAIT unreachable when it is undefined.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-transaction, clear the following immediately and abandon any in-flight request with no write committed:
- FSM to IDLE.
- ita_o_ready=0 and ita_o_rdata=0.
- irq_o=0.
- CTRL, STATUS, COUNT and SCRATCH to 0.
- COMPARE to 32'hFFFF_FFFF.

Structure
REQ-026 SHALL take register offsets, CTRL bit positions, FSM state encodings and the COMPARE reset value from a shared defines file ita_defines.v, included alongside mcu_defines.v.
REQ-027 SHALL place COUNT, COMPARE, match and reload logic in the sub-module ita_timer_core; bus FSM and decode stay in ita_periph_resp.

Verification
REQ-028 SHALL verify write SCRATCH=32'hDEAD_BEEF then read it -> ready 1 cycle after each valid (2 with ITA_RESP_WAIT_EN), rdata=32'hDEAD_BEEF.
REQ-029 SHALL verify COMPARE=5, CTRL=3'b011 -> match and irq_o=1 when COUNT reaches 5; write STATUS=1 -> irq_o=0 next cycle.
REQ-030 SHALL verify CTRL=3'b101, COMPARE=3 -> COUNT sequence 0,1,2,3,0,1,... with match set.
REQ-031 SHALL verify COUNT written to 32'hFFFF_FFFE with en=1 -> reads FFFF_FFFF then 0; a bus write to COUNT in the same cycle as an increment wins.
REQ-032 SHALL verify a read of BASE_ADDR+0x20 -> rdata=0 with ready; a write there leaves all registers unchanged.
REQ-033 SHALL verify rst_n pulsed low during WAIT/RESP of a SCRATCH write -> SCRATCH=0, ready=0, FSM IDLE, next request served normally.
